// File: rtl/button_debouncer_if.sv
// Button debouncer bundle: synchronised inputs, debounced levels/pulses and the press-event handshake.
// btn_release exists only when BUTTON_DEBOUNCER_RELEASE_EN is defined.
interface button_debouncer_if #(
    parameter int N_BUTTONS = 4,
    parameter int ID_W      = 2
);
    logic [N_BUTTONS-1:0] btn_sync;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_press;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic [N_BUTTONS-1:0] btn_release;
`endif
    logic                 press_valid;
    logic [ID_W-1:0]      press_id;
    logic                 press_ready;
    logic                 press_overrun;

    modport master (
        input  btn_sync,
        input  press_ready,
        output btn_level,
        output btn_press,
        output press_valid,
        output press_id,
        output press_overrun
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        , output btn_release
`endif
    );

    modport slave (
        output btn_sync,
        output press_ready,
        input  btn_level,
        input  btn_press,
        input  press_valid,
        input  press_id,
        input  press_overrun
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        , input  btn_release
`endif
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel debouncer with per-channel stability FSMs and a one-entry press-event register.
// Optional release pulses are enabled by defining BUTTON_DEBOUNCER_RELEASE_EN.
module button_debouncer #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    button_debouncer_if.master bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int ID_W  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        RISING,
        STABLE_HIGH,
        FALLING
    } state_t;

    logic [N_BUTTONS-1:0] press_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             press_reg;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            logic             release_reg;
`endif

            // cnt_reg counts consecutive samples disagreeing with the debounced level
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg   <= STABLE_LOW;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                    release_reg <= 1'b0;
`endif
                end else begin
                    press_reg   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                    release_reg <= 1'b0;
`endif
                    case (state_reg)
                        STABLE_LOW: begin
                            if (bus.btn_sync[gi]) begin
                                state_reg <= RISING;
                                cnt_reg   <= CNT_W'(1);
                            end
                        end
                        RISING: begin
                            if (!bus.btn_sync[gi]) begin
                                state_reg <= STABLE_LOW;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_MAX) begin
                                state_reg <= STABLE_HIGH;
                                cnt_reg   <= '0;
                                level_reg <= 1'b1;
                                press_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        STABLE_HIGH: begin
                            if (!bus.btn_sync[gi]) begin
                                state_reg <= FALLING;
                                cnt_reg   <= CNT_W'(1);
                            end
                        end
                        FALLING: begin
                            if (bus.btn_sync[gi]) begin
                                state_reg <= STABLE_HIGH;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_MAX) begin
                                state_reg   <= STABLE_LOW;
                                cnt_reg     <= '0;
                                level_reg   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                                release_reg <= 1'b1;
`endif
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_reg <= STABLE_LOW;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign bus.btn_level[gi] = level_reg;
            assign press_vec[gi]     = press_reg;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            assign bus.btn_release[gi] = release_reg;
`endif
        end
    endgenerate

    assign bus.btn_press = press_vec;

    logic [ID_W-1:0] win_id;
    logic            multi_press;
    logic            load_ok;
    logic            press_valid_reg;
    logic [ID_W-1:0] press_id_reg;
    logic            press_overrun_reg;

    // Lowest-index pressed channel wins arbitration
    always_comb begin
        win_id = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (press_vec[i]) win_id = ID_W'(i);
        end
    end

    assign multi_press = |(press_vec & (press_vec - N_BUTTONS'(1)));
    assign load_ok     = ~press_valid_reg | bus.press_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_valid_reg   <= 1'b0;
            press_id_reg      <= '0;
            press_overrun_reg <= 1'b0;
        end else begin
            press_overrun_reg <= 1'b0;
            if (|press_vec) begin
                if (load_ok) begin
                    press_valid_reg   <= 1'b1;
                    press_id_reg      <= win_id;
                    press_overrun_reg <= multi_press;
                end else begin
                    press_overrun_reg <= 1'b1;
                end
            end else if (press_valid_reg && bus.press_ready) begin
                press_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.press_valid   = press_valid_reg;
    assign bus.press_id      = press_id_reg;
    assign bus.press_overrun = press_overrun_reg;
endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios then random bouncing inputs,
// compared against a sliding-window reference model of the debounce rule.
module tb_button_debouncer;
    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_debouncer_if #(.N_BUTTONS(N), .ID_W(2)) bus();

    button_debouncer #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: a channel's level flips once its last D samples all disagree with it
    logic [N-1:0] m_level, m_press, m_release;
    logic [D-1:0] m_hist [N];
    logic         m_valid, m_ovr;
    logic [1:0]   m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_id      = '0;
        for (int i = 0; i < N; i++) m_hist[i] = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},   32'(bus.btn_level),     32'(m_level));
        check({tag, ".press"},   32'(bus.btn_press),     32'(m_press));
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        check({tag, ".release"}, 32'(bus.btn_release),   32'(m_release));
`endif
        check({tag, ".valid"},   32'(bus.press_valid),   32'(m_valid));
        check({tag, ".id"},      32'(bus.press_id),      32'(m_id));
        check({tag, ".overrun"}, 32'(bus.press_overrun), 32'(m_ovr));
    endtask

    task automatic tick(input string tag, input logic [N-1:0] btn, input logic rdy);
        logic         nvalid, novr;
        logic [1:0]   nid;
        logic [N-1:0] nlevel, npress, nrel;
        bus.btn_sync    = btn;
        bus.press_ready = rdy;
        nvalid = m_valid;
        nid    = m_id;
        novr   = 1'b0;
        if (|m_press) begin
            if (!m_valid || rdy) begin
                nvalid = 1'b1;
                for (int i = N - 1; i >= 0; i--) if (m_press[i]) nid = 2'(i);
                novr = ($countones(m_press) > 1);
            end else begin
                novr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            nvalid = 1'b0;
        end
        nlevel = m_level;
        npress = '0;
        nrel   = '0;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = {m_hist[i][D-2:0], btn[i]};
            if (m_hist[i] == {D{~m_level[i]}}) begin
                nlevel[i] = ~m_level[i];
                if (nlevel[i]) npress[i] = 1'b1;
                else           nrel[i]   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_level   = nlevel;
        m_press   = npress;
        m_release = nrel;
        m_valid   = nvalid;
        m_id      = nid;
        m_ovr     = novr;
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int n, input logic [N-1:0] btn, input logic rdy);
        for (int k = 0; k < n; k++) tick(tag, btn, rdy);
    endtask

    initial begin
        logic [N-1:0] tgt, btn;
        int           ch;

        reset           = 1'b1;
        bus.btn_sync    = '0;
        bus.press_ready = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Clean press on channel 1
        ticks("clean", 3, 4'b0010, 1'b0);
        tick("clean", 4'b0010, 1'b0);
        check("clean.level1_edge4", 32'(bus.btn_level[1]), 32'd1);
        check("clean.press_edge4",  32'(bus.btn_press),    32'h2);
        tick("clean", 4'b0010, 1'b0);
        check("clean.valid_edge5",  32'(bus.press_valid),  32'd1);
        check("clean.id_edge5",     32'(bus.press_id),     32'd1);
        tick("clean", 4'b0010, 1'b1);
        check("clean.valid_taken",  32'(bus.press_valid),  32'd0);
        ticks("clean_rel", 5, 4'b0000, 1'b0);

        // Bounce on channel 0 never reaches D consecutive samples
        for (int r = 0; r < 4; r++) begin
            ticks("bounce", 3, 4'b0001, 1'b0);
            tick("bounce", 4'b0000, 1'b0);
        end
        check("bounce.level0", 32'(bus.btn_level[0]), 32'd0);
        check("bounce.valid",  32'(bus.press_valid),  32'd0);

        // Simultaneous presses on channels 3 and 2
        ticks("simul", 5, 4'b1100, 1'b0);
        check("simul.id",      32'(bus.press_id),      32'd2);
        check("simul.overrun", 32'(bus.press_overrun), 32'd1);
        tick("simul", 4'b1100, 1'b0);
        check("simul.overrun_once", 32'(bus.press_overrun), 32'd0);
        tick("simul", 4'b1100, 1'b1);
        ticks("simul_rel", 5, 4'b0000, 1'b0);

        // Backpressure: channel 0 held, channel 3 press dropped
        ticks("bp", 5, 4'b0001, 1'b0);
        ticks("bp", 5, 4'b1001, 1'b0);
        check("bp.overrun", 32'(bus.press_overrun), 32'd1);
        check("bp.id_held", 32'(bus.press_id),      32'd0);
        tick("bp", 4'b1001, 1'b1);
        check("bp.valid_cleared", 32'(bus.press_valid), 32'd0);
        ticks("bp_rel", 5, 4'b0000, 1'b0);

        // Handover coinciding with a new load
        ticks("ho", 5, 4'b0001, 1'b0);
        ticks("ho", 4, 4'b0011, 1'b0);
        tick("ho", 4'b0011, 1'b1);
        check("ho.valid", 32'(bus.press_valid), 32'd1);
        check("ho.id",    32'(bus.press_id),    32'd1);
        tick("ho", 4'b0011, 1'b1);
        ticks("ho_rel", 5, 4'b0000, 1'b0);

        // Release of channel 2, then reset mid-RISING
        ticks("rel", 5, 4'b0100, 1'b0);
        tick("rel", 4'b0100, 1'b1);
        ticks("rel", 3, 4'b0000, 1'b0);
        tick("rel", 4'b0000, 1'b0);
        check("rel.level2", 32'(bus.btn_level[2]), 32'd0);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        check("rel.release2", 32'(bus.btn_release), 32'h4);
`endif
        ticks("rel", 2, 4'b0000, 1'b0);
        ticks("rst_mid", 2, 4'b0100, 1'b0);
        #2 reset = 1'b1;
        #1;
        reset_model();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b0;
        ticks("after_rst", 3, 4'b0100, 1'b0);
        check("after_rst.level2_not_yet", 32'(bus.btn_level[2]), 32'd0);
        tick("after_rst", 4'b0100, 1'b0);
        check("after_rst.level2", 32'(bus.btn_level[2]), 32'd1);
        ticks("after_rst", 2, 4'b0100, 1'b1);

        // Random bouncing inputs with random backpressure
        tgt = 4'b0100;
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) tgt[i] = ~tgt[i];
            btn = tgt;
            if ($urandom_range(0, 4) == 0) begin
                ch = int'($urandom_range(0, N - 1));
                btn[ch] = ~btn[ch];
            end
            tick("rand", btn, ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
